// File: rtl/whack_pkg.sv
// Shared constants and FSM encoding for the whack-a-mole input path.
package whack_pkg;

   localparam int N_HOLES_DEF          = 4;
   localparam int DEBOUNCE_CYCLES_DEF  = 1000000;
   localparam int DEBOUNCE_CYCLES_SIM  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIT  = 2'd1,
      MISS = 2'd2,
      GAP  = 2'd3
   } hit_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser followed by a stable-level debounce counter.
module btn_debounce
   import whack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic level
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync_b == level) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt   <= '0;
         level <= sync_b;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hit_detector.sv
// Debounces hole buttons, judges presses against lit moles and emits spaced hit/miss pulses.
module hit_detector
   import whack_pkg::*;
#(
   parameter int N_HOLES         = N_HOLES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N_HOLES-1:0] btn,
   input  logic [N_HOLES-1:0] mole_active,
   input  logic               game_en,
   output logic               score_inc,
   output logic               miss,
   output logic [N_HOLES-1:0] mole_clear,
   output logic [N_HOLES-1:0] btn_level
);

   localparam int IW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

   logic [N_HOLES-1:0] level_d;
   logic [N_HOLES-1:0] press;
   logic [N_HOLES-1:0] pending;
   logic [N_HOLES-1:0] pending_nxt;
   logic [N_HOLES-1:0] pend_hit;
   logic [N_HOLES-1:0] pend_hit_nxt;
   logic [N_HOLES-1:0] clr_mask;
   logic [IW-1:0]      sel_idx;
   logic [IW-1:0]      k_q;
   logic [IW-1:0]      k_nxt;
   logic               any_pend;
   hit_state_e         state;
   hit_state_e         state_nxt;

   for (genvar g = 0; g < N_HOLES; g++) begin : g_db
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset_n(reset_n),
         .raw    (btn[g]),
         .level  (btn_level[g])
      );
   end

   assign press = btn_level & ~level_d;

   always_comb begin
      sel_idx  = '0;
      any_pend = 1'b0;
      for (int unsigned i = 0; i < N_HOLES; i++) begin
         if (pending[i] && !any_pend) begin
            sel_idx  = IW'(i);
            any_pend = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k_q;
      clr_mask  = '0;
      case (state)
         IDLE: begin
            if (game_en && any_pend) begin
               k_nxt             = sel_idx;
               clr_mask[sel_idx] = 1'b1;
               state_nxt         = pend_hit[sel_idx] ? HIT : MISS;
            end
         end
         HIT:     state_nxt = GAP;
         MISS:    state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A fresh press on the bit being served re-arms it; repeat presses merge.
   always_comb begin
      pending_nxt  = '0;
      pend_hit_nxt = pend_hit;
      if (game_en) begin
         pending_nxt  = (pending & ~clr_mask) | press;
         pend_hit_nxt = (pend_hit & ~press) | (mole_active & press);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_d  <= '0;
         pending  <= '0;
         pend_hit <= '0;
         state    <= IDLE;
         k_q      <= '0;
      end else begin
         level_d  <= btn_level;
         pending  <= pending_nxt;
         pend_hit <= pend_hit_nxt;
         state    <= state_nxt;
         k_q      <= k_nxt;
      end
   end

   // Pulses are registered from the next state so they align with HIT/MISS.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         score_inc  <= 1'b0;
         miss       <= 1'b0;
         mole_clear <= '0;
      end else begin
         score_inc  <= (state_nxt == HIT);
         miss       <= (state_nxt == MISS);
         mole_clear <= (state_nxt == HIT) ? (N_HOLES'(1) << k_nxt) : '0;
      end
   end

endmodule

// File: doc/hit_detector.md
Name: hit_detector

Overview:
- Input-side producer of the scoreboard's `score_inc` pulse stream.
- Synchronises and debounces the raw Basys3 hole buttons and detects press events.
- Judges each press against the mole currently lit in that hole.
- Emits one clean single-cycle `score_inc` (hit) or `miss` pulse per press, each followed by a guaranteed low gap, so the scoreboard's rising-edge detector counts every hit.
- Tells the mole generator which mole to retire.

Parameters:
- N_HOLES, 4, number of buttons/holes.
- DEBOUNCE_CYCLES, 1000000, stable-input cycles before a debounced level changes (10 ms at 100 MHz); ≥2.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- btn  input  N_HOLES  raw asynchronous push buttons, active high.
- mole_active  input  N_HOLES  moles currently up, synchronous to clk; any pattern legal.
- game_en  input  1  high while a round is running.
- score_inc  output  1  one-cycle hit pulse to the scoreboard.
- miss  output  1  one-cycle miss pulse.
- mole_clear  output  N_HOLES  one-hot retire strobe, coincident with `score_inc`.
- btn_level  output  N_HOLES  debounced button levels.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Clears synchronisers, debounce counters, btn_level, pending and pend_hit registers, FSM (to IDLE), score_inc, miss and mole_clear, all to 0.
  - Takes effect immediately, including mid-pulse.
- Per button, two-flop synchroniser → `sync[i]`.
- Debounce counter per button:
  - If `sync[i] == btn_level[i]`, the counter clears to 0.
  - Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, `btn_level[i]` takes `sync[i]` and the counter clears.
  - A raw level held for fewer than DEBOUNCE_CYCLES synced cycles never changes `btn_level`.
- Press edge:
  - A 0→1 transition of `btn_level[i]` at cycle T registers `pending[i]=1` at T+1.
  - At the same time it registers `pend_hit[i] = mole_active[i]`, sampled at T.
  - Releases generate nothing.
- game_en low:
  - Press edges are ignored and `pending` is cleared every cycle.
  - The FSM finishes any HIT/MISS/GAP in progress.
- FSM states:
  - IDLE:
    - If any pending bit is set, select the lowest index k.
    - Go to HIT if `pend_hit[k]`, else MISS.
    - Clear `pending[k]` on this transition.
  - HIT:
    - `score_inc=1`.
    - `mole_clear = 1<<k`.
    - Next state GAP.
  - MISS:
    - `miss=1`.
    - Next state GAP.
  - GAP:
    - All pulses 0.
    - Next state IDLE.
- Outputs are registered decodes of the state: each pulse is exactly one cycle, and the minimum spacing between pulses is 2 low cycles.
- Latency: edge at T → pending at T+1 → HIT/MISS visible at T+2.
- Simultaneous edges: all are latched; they are served in ascending index order, one per 3-cycle service slot.
- A new edge on a bit in the same cycle it is being cleared: the set wins.
- A further press on an already-pending button is merged into that pending entry (not queued twice).

Decomposition:
- Shared package `whack_pkg`:
  - N_HOLES default.
  - FSM state encoding (IDLE, HIT, MISS, GAP; 2 bits).
  - DEBOUNCE_CYCLES default and a simulation override constant of 4.
- Sub-module `btn_debounce`:
  - Contains the synchroniser, counter and stable level.
  - Parameter DEBOUNCE_CYCLES; ports clk, reset_n, raw, level.
  - Instantiated N_HOLES times via generate.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset:
   - Stimulus: hold reset_n low 3 cycles, then assert it low again one cycle into HIT.
   - Required: all outputs 0 immediately; score_inc drops in the same cycle; pending cleared.
2. Single hit:
   - Stimulus: mole_active=4'b0100, game_en=1; btn[2] held high 20 cycles.
   - Required: exactly one score_inc pulse with mole_clear=4'b0100 in the same cycle, 2 cycles after btn_level[2] rises; miss stays 0.
3. Bounce rejection:
   - Stimulus: btn[0] toggled high 2 cycles / low 2 cycles for 40 cycles.
   - Required: btn_level[0] stays 0; no pulses.
4. Miss:
   - Stimulus: mole_active=4'b0001; btn[1] pressed.
   - Required: one miss pulse; score_inc=0; mole_clear=0.
5. Simultaneous press with scoreboard attached:
   - Stimulus: mole_active=4'b1001; btn[0] and btn[3] rise in the same cycle.
   - Required: score_inc pulses at cycles t and t+3, with mole_clear 0001 then 1000; scoreboard score goes from 0 to 2.
6. Game disabled:
   - Stimulus: game_en=0; btn[2] pressed with mole_active=4'b0100.
   - Required: no score_inc, miss or mole_clear; btn_level[2] still follows the debounced input.
